// File: rtl/seq_detect_fsm.sv
// seq_detect_fsm: parametrised MSB-first serial pattern detector.
// The matched-prefix length is the FSM state. The next state for every
// (state, In) pair is a constant table built from PATTERN when the design is
// elaborated, which is the KMP automaton unrolled. Out and count are
// registered, so no combinational path runs from In to any output.
module seq_detect_fsm #(
  parameter int          N       = 4,
  parameter logic [15:0] PATTERN = 16'h000B,
  parameter bit          OVERLAP = 1'b1,
  parameter int          CNT_W   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 en,
  input  logic                 In,
  output logic                 Out,
  output logic [CNT_W-1:0]     count,
  output logic [$clog2(N):0]   state
);

  localparam int SW = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Control action decoded for each edge. clear outranks en.
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_STEP  = 2'd1,
    ACT_CLEAR = 2'd2
  } act_e;

  // Longest j <= k+1 where the last j bits of (PATTERN prefix of length k,
  // followed by b) equal the first j bits of PATTERN. A result of N means a
  // full match.
  function automatic logic [SW-1:0] next_len(input int k, input logic b);
    logic [16:0] seq;
    logic        ok;
    int          best;
    seq  = 17'd0;
    best = 0;
    for (int i = 0; i < k; i++) begin
      seq[i] = PATTERN[N-1-i];
    end
    seq[k] = b;
    for (int j = 1; j <= N; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int t = 0; t < j; t++) begin
          if (seq[k+1-j+t] != PATTERN[N-1-t]) begin
            ok = 1'b0;
          end
        end
        if (ok) begin
          best = j;
        end
      end
    end
    return SW'(best);
  endfunction

  // Longest proper border of PATTERN: the prefix already matched once a
  // full match is accepted in overlap mode.
  function automatic logic [SW-1:0] border_len();
    logic ok;
    int   best;
    best = 0;
    for (int j = 1; j < N; j++) begin
      ok = 1'b1;
      for (int t = 0; t < j; t++) begin
        if (PATTERN[j-1-t] != PATTERN[N-1-t]) begin
          ok = 1'b0;
        end
      end
      if (ok) begin
        best = j;
      end
    end
    return SW'(best);
  endfunction

  localparam logic [SW-1:0] BORDER = border_len();
  localparam logic [SW-1:0] FULL   = SW'(N);

  // Reject unsupported lengths and patterns with bits above N.
  if (N < 2 || N > 16) begin : g_bad_n
    $error("seq_detect_fsm: N=%0d outside 2..16", N);
  end
  if (N < 16) begin : g_pat_chk
    if ((PATTERN >> N) != 16'h0000) begin : g_bad_pattern
      $error("seq_detect_fsm: PATTERN has bits above position N-1");
    end
  end

  logic [SW-1:0]    tab0_s [N];
  logic [SW-1:0]    tab1_s [N];
  logic [SW-1:0]    state_r;
  logic             out_r;
  logic [CNT_W-1:0] count_r;
  logic [SW-1:0]    cand_s;
  logic             match_s;
  act_e             act_s;
  logic [SW-1:0]    state_nxt_s;
  logic             out_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;

  for (genvar k = 0; k < N; k++) begin : g_tab
    localparam logic [SW-1:0] NXT0 = next_len(k, 1'b0);
    localparam logic [SW-1:0] NXT1 = next_len(k, 1'b1);
    assign tab0_s[k] = NXT0;
    assign tab1_s[k] = NXT1;
  end

  // Next state, pulse and count from (state, In) and the control inputs.
  always_comb begin
    cand_s      = {SW{1'b0}};
    state_nxt_s = state_r;
    out_nxt_s   = 1'b0;
    count_nxt_s = count_r;
    for (int k = 0; k < N; k++) begin
      cand_s = (state_r == SW'(k)) ? (In ? tab1_s[k] : tab0_s[k]) : cand_s;
    end
    match_s = (cand_s == FULL);
    if (clear) begin
      act_s = ACT_CLEAR;
    end else if (en) begin
      act_s = ACT_STEP;
    end else begin
      act_s = ACT_HOLD;
    end
    case (act_s)
      ACT_CLEAR: begin
        state_nxt_s = {SW{1'b0}};
        out_nxt_s   = 1'b0;
        count_nxt_s = {CNT_W{1'b0}};
      end
      ACT_STEP: begin
        if (match_s) begin
          state_nxt_s = OVERLAP ? BORDER : {SW{1'b0}};
          out_nxt_s   = 1'b1;
          count_nxt_s = (count_r == CNT_MAX) ? count_r : count_r + CNT_W'(1);
        end else begin
          state_nxt_s = cand_s;
          out_nxt_s   = 1'b0;
          count_nxt_s = count_r;
        end
      end
      ACT_HOLD: begin
        state_nxt_s = state_r;
        out_nxt_s   = 1'b0;
        count_nxt_s = count_r;
      end
      default: begin
        state_nxt_s = {SW{1'b0}};
        out_nxt_s   = 1'b0;
        count_nxt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, pulse and counter registers; reset acts without waiting for a clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= {SW{1'b0}};
      out_r   <= 1'b0;
      count_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      out_r   <= out_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  assign state = state_r;
  assign Out   = out_r;
  assign count = count_r;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Testbench for seq_detect_fsm: table-driven vectors on three instances
// (1011 overlap, 1011 non-overlap, 11 with a 2-bit counter) plus a
// hand-written asynchronous reset sequence.
module tb_seq_detect_fsm;

  typedef struct {
    logic clr;
    logic en;
    logic in;
    logic out;
    int   st;
    int   cnt;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic       clear_a = 1'b0, en_a = 1'b0, in_a = 1'b0, out_a;
  logic [7:0] count_a;
  logic [2:0] state_a;
  logic       clear_b = 1'b0, en_b = 1'b0, in_b = 1'b0, out_b;
  logic [7:0] count_b;
  logic [2:0] state_b;
  logic       clear_c = 1'b0, en_c = 1'b0, in_c = 1'b0, out_c;
  logic [1:0] count_c;
  logic [1:0] state_c;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t va [31];
  vec_t vb [7];
  vec_t vc [7];

  seq_detect_fsm #(.N(4), .PATTERN(16'h000B), .OVERLAP(1'b1), .CNT_W(8)) u_a (
    .clock(clock), .reset(reset), .clear(clear_a), .en(en_a), .In(in_a),
    .Out(out_a), .count(count_a), .state(state_a));

  seq_detect_fsm #(.N(4), .PATTERN(16'h000B), .OVERLAP(1'b0), .CNT_W(8)) u_b (
    .clock(clock), .reset(reset), .clear(clear_b), .en(en_b), .In(in_b),
    .Out(out_b), .count(count_b), .state(state_b));

  seq_detect_fsm #(.N(2), .PATTERN(16'h0003), .OVERLAP(1'b1), .CNT_W(2)) u_c (
    .clock(clock), .reset(reset), .clear(clear_c), .en(en_c), .In(in_c),
    .Out(out_c), .count(count_c), .state(state_c));

  always #5 clock = ~clock;

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // 1011, overlap: columns are clr, en, In -> Out, state, count
    va[ 0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 0};
    va[ 1] = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 0};
    va[ 2] = '{1'b0, 1'b1, 1'b1, 1'b0, 3, 0};
    va[ 3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1, 1};
    va[ 4] = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 1};
    va[ 5] = '{1'b0, 1'b1, 1'b1, 1'b0, 3, 1};
    va[ 6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1, 2};
    va[ 7] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
    va[ 8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 0};
    va[ 9] = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 0};
    va[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 3, 0};
    va[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 3, 0};
    va[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 3, 0};
    va[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 3, 0};
    va[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1, 1};
    va[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1};
    va[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 1};
    va[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 3, 1};
    va[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 0};
    va[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
    va[20] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 0};
    va[21] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 0};
    va[22] = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 0};
    va[23] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
    va[24] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 0};
    va[25] = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 0};
    va[26] = '{1'b0, 1'b1, 1'b1, 1'b0, 3, 0};
    va[27] = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 0};
    va[28] = '{1'b0, 1'b1, 1'b1, 1'b0, 3, 0};
    va[29] = '{1'b0, 1'b1, 1'b1, 1'b1, 1, 1};
    va[30] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0};
    // 1011, no overlap: stream 1,0,1,1,0,1,1
    vb[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 0};
    vb[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 0};
    vb[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 3, 0};
    vb[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 0, 1};
    vb[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1};
    vb[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 1};
    vb[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 1};
    // 11, overlap, 2-bit counter: six ones then a zero
    vc[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 0};
    vc[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1, 1};
    vc[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1, 2};
    vc[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1, 3};
    vc[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1, 3};
    vc[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1, 3};
    vc[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 3};

    // Power-on reset
    #2;
    chk("rst_state", 0, state_a, 0);
    chk("rst_out",   0, out_a,   0);
    chk("rst_count", 0, count_a, 0);
    tick();
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 31; i++) begin
      clear_a = va[i].clr; en_a = va[i].en; in_a = va[i].in;
      tick();
      chk("a_out",   i, out_a,   va[i].out);
      chk("a_state", i, state_a, va[i].st);
      chk("a_count", i, count_a, va[i].cnt);
    end

    // Asynchronous reset in the middle of a cycle with state=3
    clear_a = 1'b0; en_a = 1'b1;
    in_a = 1'b1; tick();
    in_a = 1'b0; tick();
    in_a = 1'b1; tick();
    in_a = 1'b1; tick();
    chk("pre_out", 0, out_a, 1);
    in_a = 1'b0; tick();
    in_a = 1'b1; tick();
    chk("pre_state", 0, state_a, 3);
    chk("pre_count", 0, count_a, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_state", 0, state_a, 0);
    chk("async_out",   0, out_a,   0);
    chk("async_count", 0, count_a, 0);
    for (int i = 1; i <= 2; i++) begin
      tick();
      chk("hold_state", i, state_a, 0);
      chk("hold_out",   i, out_a,   0);
      chk("hold_count", i, count_a, 0);
    end
    @(negedge clock);
    reset = 1'b0;
    in_a = 1'b1;
    tick();
    chk("post_state", 0, state_a, 1);
    chk("post_out",   0, out_a,   0);
    en_a = 1'b0;

    for (int i = 0; i < 7; i++) begin
      clear_b = vb[i].clr; en_b = vb[i].en; in_b = vb[i].in;
      tick();
      chk("b_out",   i, out_b,   vb[i].out);
      chk("b_state", i, state_b, vb[i].st);
      chk("b_count", i, count_b, vb[i].cnt);
    end
    en_b = 1'b0;

    for (int i = 0; i < 7; i++) begin
      clear_c = vc[i].clr; en_c = vc[i].en; in_c = vc[i].in;
      tick();
      chk("c_out",   i, out_c,   vc[i].out);
      chk("c_state", i, state_c, vc[i].st);
      chk("c_count", i, count_c, vc[i].cnt);
    end
    en_c = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
